shift_left_seq: RTL and testbench

SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

---
 rtl/shift_left_seq.sv | 96 +++++++++
 tb/tb_shift_left_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_left_seq.sv
// Multi-cycle barrel shifter: one log-stage per cycle (5 stages for N=32), with a
// valid/ready handshake on both sides and a fixed accept-to-result latency of 6 cycles.
module shift_left_seq #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 busy
);

  localparam int SW = $clog2(N);
  localparam logic [2:0] LAST_STAGE = 3'(SW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [2:0]      stage;
  logic [N-1:0]    work;
  logic [SW-1:0]   shamt_q;
  logic            mode_q;

  logic            accept;
  logic [7:0]      shamt_ext;
  logic            stage_en;
  logic [SW:0]     amt;
  logic [2*N-1:0]  doubled;
  logic [N-1:0]    stage_result;

  assign accept = in_valid && in_ready;

  // Rotation reads the upper half of {work,work} shifted left; stage amount is never 0 or N.
  always_comb begin
    shamt_ext    = {{(8-SW){1'b0}}, shamt_q};
    stage_en     = shamt_ext[stage];
    amt          = {{SW{1'b0}}, 1'b1} << stage;
    doubled      = {work, work} << amt;
    stage_result = work;
    if (stage_en) begin
      if (mode_q) stage_result = doubled[2*N-1:N];
      else        stage_result = work << amt;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (stage == LAST_STAGE) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stage   <= '0;
      work    <= '0;
      shamt_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        work    <= in;
        shamt_q <= shamt;
        mode_q  <= mode;
        stage   <= '0;
      end else if (state == BUSY) begin
        work  <= stage_result;
        stage <= stage + 3'd1;
      end
    end
  end

  assign out  = work;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed bench for shift_left_seq: handshake timing, shift/rotate results,
// backpressure hold, reset abort, and a short run of back-to-back requests.
module tb_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  shift_left_seq #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in), .shamt(shamt), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic m);
    logic [31:0] r;
    r = a << s;
    if (m && s != 5'd0) r = r | (a >> (6'd32 - {1'b0, s}));
    return r;
  endfunction

  // Accept in cycle 0, check idle-handshake outputs in cycles 1..5, result in cycle 6.
  task automatic run(input string tag, input logic [31:0] a, input logic [4:0] s,
                     input logic m, input logic [31:0] exp_out, input logic hold);
    check({tag, "_in_ready0"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in = a; shamt = s; mode = m; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      in = ~in; shamt = shamt + 5'd3; mode = ~mode;
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      check({tag, "_out_valid_busy"}, 32'(out_valid), 32'd0);
      step();
    end
    check({tag, "_out_valid6"}, 32'(out_valid), 32'd1);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_in_ready6"}, 32'(in_ready), 32'd0);
    if (hold) begin
      for (int c = 0; c < 10; c++) begin
        in = $urandom; shamt = 5'($urandom); mode = ~mode;
        step();
        check({tag, "_hold_out"}, out, exp_out);
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [4:0]  s;
    logic        m;
    int unsigned waited;

    rst = 1'b1; in_valid = 1'b1; in = 32'hFFFF_FFFF; shamt = 5'd7; mode = 1'b1; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", out, 32'h0);

    run("lsl31",      32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b0);
    run("rol4",       32'h8000_0001, 5'd4,  1'b1, 32'h0000_0018, 1'b0);
    run("lsl4",       32'h8000_0001, 5'd4,  1'b0, 32'h0000_0010, 1'b0);
    run("lsl0",       32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0);
    run("rol0",       32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0);
    run("rol8",       32'h1234_5678, 5'd8,  1'b1, 32'h3456_7812, 1'b0);
    run("rol1",       32'hF000_0000, 5'd1,  1'b1, 32'hE000_0001, 1'b0);
    run("rol31",      32'h0000_0003, 5'd31, 1'b1, 32'h8000_0001, 1'b0);
    run("lsl16_hold", 32'hFFFF_FFFF, 5'd16, 1'b0, 32'hFFFF_0000, 1'b1);

    // Reset during BUSY: accept, reach cycle 3, assert rst for one edge.
    in_valid = 1'b1; in = 32'hA5A5_A5A5; shamt = 5'd5; mode = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", out, 32'h0);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    out_ready = 1'b0;

    // Back-to-back requests with random backpressure, each waited on with a bound.
    for (int t = 0; t < 40; t++) begin
      a = $urandom; s = 5'($urandom); m = 1'($urandom);
      in_valid = 1'b1; in = a; shamt = s; mode = m;
      waited = 0;
      while (!in_ready && waited < 50) begin step(); waited++; end
      check("b2b_accept_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; in = ~a; shamt = ~s; mode = ~m;
      waited = 0;
      while (!out_valid && waited < 20) begin
        out_ready = 1'($urandom);
        step();
        waited++;
      end
      check("b2b_latency", waited, 32'd5);
      while (out_valid && !out_ready) begin
        check("b2b_hold", out, model(a, s, m));
        out_ready = 1'($urandom);
        if (out_valid && !out_ready) step();
      end
      check("b2b_out", out, model(a, s, m));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
